// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared FSM encoding, widths and saturation helper for softmax_normalizer
package softmax_pkg;

  localparam int DEF_NUM_INPUTS = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  // Quotient bits per lane before any rounding bit, and the counter widths that go with it
  localparam int QW  = DEF_DATA_WIDTH + DEF_FRAC_BITS;
  localparam int QCW = $clog2(QW + 1);
  localparam int LCW = $clog2(DEF_NUM_INPUTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Clamp an unsigned value to the largest dw-bit number
  function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int unsigned dw);
    logic [63:0] lim;
    lim = (64'd1 << dw) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring divider, one quotient bit per cycle
module serial_divider
  import softmax_pkg::*;
#(
  parameter int NUM_W = QW,
  parameter int DEN_W = DEF_DATA_WIDTH,
  parameter int Q_W   = QW,
  parameter int CNT_W = QCW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  logic             load;
  logic [NUM_W-1:0] num_sh;
  logic [NUM_W-1:0] cur_num;
  logic [DEN_W:0]   rem;
  logic [DEN_W:0]   cur_rem;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   rem_nxt;
  logic [Q_W-1:0]   quot;
  logic [Q_W-1:0]   cur_q;
  logic [CNT_W-1:0] cnt;
  logic             fits;

  // The start cycle already produces the first quotient bit from the fresh operands;
  // once the numerator is exhausted zeros shift in, giving any extra (rounding) bits.
  always_comb begin
    load    = start && !busy;
    cur_num = load ? dividend : num_sh;
    cur_rem = load ? '0 : rem;
    cur_q   = load ? '0 : quot;
    trial   = (cur_rem << 1) | {{DEN_W{1'b0}}, cur_num[NUM_W-1]};
    fits    = (trial >= {1'b0, divisor});
    rem_nxt = fits ? (trial - {1'b0, divisor}) : trial;
  end

  // Quotient including the bit being decided this cycle; final when done is high
  assign quotient = (cur_q << 1) | Q_W'(fits);
  assign done     = busy && (cnt == CNT_W'(Q_W - 1));

  // Iteration state: shift numerator, update remainder/quotient, count bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_sh <= '0;
      rem    <= '0;
      quot   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load || busy) begin
      num_sh <= cur_num << 1;
      rem    <= rem_nxt;
      quot   <= quotient;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        busy <= 1'b1;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/softmax_normalizer.sv
// rtl/softmax_normalizer.sv - divides each exp lane by the vector sum; SOFTMAX_NORM_ROUND_EN enables round half up
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]            in_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
  output logic                             out_div_zero,
  output logic                             busy
);

  localparam int Q_BITS = DATA_WIDTH + FRAC_BITS;
`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int DIV_QW = Q_BITS + RND;
  localparam int CNT_W  = $clog2(Q_BITS + 1);
  localparam int LANE_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_INPUTS - 1);

  state_t                           state;
  state_t                           state_nxt;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_q;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] res_sh;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] res_nxt;
  logic [DATA_WIDTH-1:0]            sum_q;
  logic [LANE_W-1:0]                lane;
  logic                             accept;
  logic                             div_start;
  logic                             div_busy;
  logic                             div_done;
  logic [DIV_QW-1:0]                div_q;
  logic [DATA_WIDTH-1:0]            lane_in;
  logic [DATA_WIDTH-1:0]            lane_res;
  logic [Q_BITS-1:0]                dividend;

  assign lane_in  = data_q[lane*DATA_WIDTH +: DATA_WIDTH];
  assign dividend = {lane_in, {FRAC_BITS{1'b0}}};

`ifdef SOFTMAX_NORM_ROUND_EN
  // Extra quotient bit is the half bit; adding it rounds half up, overflow is caught by saturation
  logic [Q_BITS:0] rounded;
  assign rounded = {1'b0, div_q[DIV_QW-1:1]} + {{Q_BITS{1'b0}}, div_q[0]};
`else
  logic [Q_BITS-1:0] rounded;
  assign rounded = div_q;
`endif

  assign lane_res = DATA_WIDTH'(sat_unsigned(64'(rounded), DATA_WIDTH));
  assign accept   = in_valid && in_ready;

  // Result vector with the lane finishing this cycle merged in
  always_comb begin
    res_nxt = res_sh;
    res_nxt[lane*DATA_WIDTH +: DATA_WIDTH] = lane_res;
  end

  serial_divider #(
    .NUM_W (Q_BITS),
    .DEN_W (DATA_WIDTH),
    .Q_W   (DIV_QW),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (sum_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs; a lane starts whenever the divider is free in DIV
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = (in_sum == '0) ? ST_OUT : ST_DIV;
        end
      end
      ST_DIV: begin
        div_start = !div_busy;
        if (div_done && (lane == LAST_LANE)) begin
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture on accept, collect lane results, publish the vector after the last lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      sum_q        <= '0;
      lane         <= '0;
      res_sh       <= '0;
      out_data     <= '0;
      out_div_zero <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        sum_q  <= in_sum;
        lane   <= '0;
        if (in_sum == '0) begin
          out_data     <= '0;
          out_div_zero <= 1'b1;
        end else begin
          out_div_zero <= 1'b0;
        end
      end
      if (div_done) begin
        res_sh <= res_nxt;
        if (lane == LAST_LANE) begin
          lane     <= '0;
          out_data <= res_nxt;
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule
